cache_control: RTL and testbench

- Sequencing controller for the 2-way set-associative, 8-set, 32-byte-line cache datapath.
- Decodes CPU read/write requests against way hit/valid/dirty status.
- Drives array load enables, way select and physical-memory handshakes.
- Maintains per-set LRU for victim choice; write-back, write-allocate policy.

---
 rtl/cache_control.sv | 168 ++++++++++++++++
 tb/tb_cache_control.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way, 8-set, write-back/write-allocate cache with per-set LRU.
// Optional macro CACHE_PERF_CNT_EN adds hit/miss/write-back counter outputs.
module cache_control #(
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [INDEX_W-1:0] index_i,
  input  logic               hit_0_i,
  input  logic               hit_1_i,
  input  logic               valid_out_0_i,
  input  logic               valid_out_1_i,
  input  logic               dirty_out_0_i,
  input  logic               dirty_out_1_i,
  input  logic               pmem_resp_i,
  output logic               mem_resp_o,
  output logic               pmem_read_o,
  output logic               pmem_write_o,
  output logic               pmem_addr_sel_o,
  output logic               data_in_sel_o,
  output logic               load_data_0_o,
  output logic               load_tag_0_o,
  output logic               load_valid_0_o,
  output logic               load_dirty_0_o,
  output logic               load_data_1_o,
  output logic               load_tag_1_o,
  output logic               load_valid_1_o,
  output logic               load_dirty_1_o,
  output logic               valid_in_o,
  output logic               dirty_in_o,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]        hit_count_o,
  output logic [31:0]        miss_count_o,
  output logic [31:0]        wb_count_o,
`endif
  output logic               way_sel_o
);

  typedef enum logic [1:0] {
    S_CHECK = 2'd0,
    S_WB    = 2'd1,
    S_FILL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;

  logic req, hit, hit_way, victim, victim_dirty;

  assign req     = mem_read_i | mem_write_i;
  assign hit     = hit_0_i | hit_1_i;
  assign hit_way = hit_1_i & ~hit_0_i;
  assign victim  = lru_q[index_i];
  assign victim_dirty = victim ? (valid_out_1_i & dirty_out_1_i)
                               : (valid_out_0_i & dirty_out_0_i);

  // Outputs depend on same-cycle hit and pmem_resp (zero-wait hit, fill on
  // the response cycle), so they are decoded from state plus inputs.
  always_comb begin
    state_d         = state_q;
    lru_d           = lru_q;
    mem_resp_o      = 1'b0;
    pmem_read_o     = 1'b0;
    pmem_write_o    = 1'b0;
    pmem_addr_sel_o = 1'b0;
    data_in_sel_o   = 1'b0;
    load_data_0_o   = 1'b0;
    load_tag_0_o    = 1'b0;
    load_valid_0_o  = 1'b0;
    load_dirty_0_o  = 1'b0;
    load_data_1_o   = 1'b0;
    load_tag_1_o    = 1'b0;
    load_valid_1_o  = 1'b0;
    load_dirty_1_o  = 1'b0;
    valid_in_o      = 1'b0;
    dirty_in_o      = 1'b0;
    way_sel_o       = 1'b0;
    if (rst_n_i) begin
      case (state_q)
        S_CHECK: begin
          if (req && hit) begin
            mem_resp_o     = 1'b1;
            way_sel_o      = hit_way;
            lru_d[index_i] = ~hit_way;
            if (mem_write_i) begin
              data_in_sel_o = 1'b1;
              dirty_in_o    = 1'b1;
              if (hit_way) begin
                load_data_1_o  = 1'b1;
                load_dirty_1_o = 1'b1;
              end else begin
                load_data_0_o  = 1'b1;
                load_dirty_0_o = 1'b1;
              end
            end
          end else if (req) begin
            state_d = victim_dirty ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          pmem_write_o    = 1'b1;
          pmem_addr_sel_o = 1'b1;
          way_sel_o       = victim;
          if (pmem_resp_i) state_d = S_FILL;
        end
        S_FILL: begin
          pmem_read_o = 1'b1;
          way_sel_o   = victim;
          if (pmem_resp_i) begin
            valid_in_o = 1'b1;
            state_d    = S_CHECK;
            if (victim) begin
              load_data_1_o  = 1'b1;
              load_tag_1_o   = 1'b1;
              load_valid_1_o = 1'b1;
              load_dirty_1_o = 1'b1;
            end else begin
              load_data_0_o  = 1'b1;
              load_tag_0_o   = 1'b1;
              load_valid_0_o = 1'b1;
              load_dirty_0_o = 1'b1;
            end
          end
        end
        default: state_d = S_CHECK;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_CHECK;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic        hit_ev, miss_ev, wb_ev;
  logic [31:0] hit_count_q, miss_count_q, wb_count_q;

  assign hit_ev  = (state_q == S_CHECK) & req & hit;
  assign miss_ev = (state_q == S_CHECK) & req & ~hit;
  assign wb_ev   = (state_q == S_WB) & pmem_resp_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if (hit_ev)  hit_count_q  <= hit_count_q + 32'd1;
      if (miss_ev) miss_count_q <= miss_count_q + 32'd1;
      if (wb_ev)   wb_count_q   <= wb_count_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
  assign wb_count_o   = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control: emulated tag/valid/dirty arrays plus an abstract cache model.
`timescale 1ns/1ps
module tb_cache_control;
  localparam int NS = 8;
  localparam logic [1:0] K_WB = 2'd0, K_FILL = 2'd1, K_RESP = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        way;
    logic        wr;
    logic [15:0] lat;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0] index = 3'd0;
  logic hit_0, hit_1, valid_out_0, valid_out_1, dirty_out_0, dirty_out_1;
  logic pmem_resp = 1'b0;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel;
  logic load_data_0, load_tag_0, load_valid_0, load_dirty_0;
  logic load_data_1, load_tag_1, load_valid_1, load_dirty_1;
  logic valid_in, dirty_in, way_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int checks = 0, errors = 0, cyc = 0, issue_cyc = 0;
  int mem_delay = 1, mcnt = 0;
  bit resp_en = 1'b1, stray = 1'b0, dp_clr = 1'b1;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_control dut (
    .clk_i(clk), .rst_n_i(rst_n), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .index_i(index), .hit_0_i(hit_0), .hit_1_i(hit_1),
    .valid_out_0_i(valid_out_0), .valid_out_1_i(valid_out_1),
    .dirty_out_0_i(dirty_out_0), .dirty_out_1_i(dirty_out_1),
    .pmem_resp_i(pmem_resp), .mem_resp_o(mem_resp),
    .pmem_read_o(pmem_read), .pmem_write_o(pmem_write),
    .pmem_addr_sel_o(pmem_addr_sel), .data_in_sel_o(data_in_sel),
    .load_data_0_o(load_data_0), .load_tag_0_o(load_tag_0),
    .load_valid_0_o(load_valid_0), .load_dirty_0_o(load_dirty_0),
    .load_data_1_o(load_data_1), .load_tag_1_o(load_tag_1),
    .load_valid_1_o(load_valid_1), .load_dirty_1_o(load_dirty_1),
    .valid_in_o(valid_in), .dirty_in_o(dirty_in),
`ifdef CACHE_PERF_CNT_EN
    .hit_count_o(hit_count), .miss_count_o(miss_count), .wb_count_o(wb_count),
`endif
    .way_sel_o(way_sel)
  );

  // Emulated datapath arrays, written only through the DUT's load strobes.
  logic [3:0] cur_tag = 4'd0;
  logic [3:0] dp_tag [NS][2];
  logic       dp_valid [NS][2];
  logic       dp_dirty [NS][2];

  always_comb begin
    valid_out_0 = dp_valid[index][0];
    valid_out_1 = dp_valid[index][1];
    dirty_out_0 = dp_dirty[index][0];
    dirty_out_1 = dp_dirty[index][1];
    hit_0 = dp_valid[index][0] && (dp_tag[index][0] == cur_tag);
    hit_1 = dp_valid[index][1] && (dp_tag[index][1] == cur_tag);
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < 2; w++) begin
          dp_tag[s][w] <= 4'd0; dp_valid[s][w] <= 1'b0; dp_dirty[s][w] <= 1'b0;
        end
    end else begin
      if (load_tag_0)   dp_tag[index][0]   <= cur_tag;
      if (load_valid_0) dp_valid[index][0] <= valid_in;
      if (load_dirty_0) dp_dirty[index][0] <= dirty_in;
      if (load_tag_1)   dp_tag[index][1]   <= cur_tag;
      if (load_valid_1) dp_valid[index][1] <= valid_in;
      if (load_dirty_1) dp_dirty[index][1] <= dirty_in;
    end
  end

  // Memory: pmem_resp on the mem_delay-th cycle a strobe is held.
  initial forever begin
    @(posedge clk); #1;
    if (resp_en) begin
      if (pmem_resp) begin pmem_resp = 1'b0; mcnt = 0; end
      if (pmem_read || pmem_write) begin
        mcnt++;
        if (mcnt == mem_delay) pmem_resp = 1'b1;
      end else mcnt = 0;
    end else begin
      mcnt = 0;
      pmem_resp = stray;
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic exp_t pop_exp(input string nm);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: DUT event with empty scoreboard (cycle %0d)", nm, cyc);
      e = '0;
      e.kind = 2'd3;
    end else e = exp_q.pop_front();
    return e;
  endfunction

  function automatic logic [16:0] all_outs();
    return {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel,
            load_data_0, load_tag_0, load_valid_0, load_dirty_0,
            load_data_1, load_tag_1, load_valid_1, load_dirty_1,
            valid_in, dirty_in, way_sel, 1'b0};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [3:0] l0, l1, lw, lo;
    l0 = {load_data_0, load_tag_0, load_valid_0, load_dirty_0};
    l1 = {load_data_1, load_tag_1, load_valid_1, load_dirty_1};
    if (rst_n) begin
      if (pmem_resp && pmem_write) begin
        e = pop_exp("wb_event");
        chk("wb_kind", K_WB, e.kind);
        chk("wb_way_sel", way_sel, e.way);
        chk("wb_addr_sel", pmem_addr_sel, 1);
        chk("wb_no_loads", {l0, l1}, 0);
      end
      if (pmem_resp && pmem_read) begin
        e = pop_exp("fill_event");
        lw = e.way ? l1 : l0;
        lo = e.way ? l0 : l1;
        chk("fill_kind", K_FILL, e.kind);
        chk("fill_way_sel", way_sel, e.way);
        chk("fill_victim_loads", lw, 4'hF);
        chk("fill_other_way_loads", lo, 0);
        chk("fill_sel_vin_din", {pmem_addr_sel, data_in_sel, valid_in, dirty_in}, 4'b0010);
      end
      if (mem_resp) begin
        e = pop_exp("resp_event");
        lw = way_sel ? l1 : l0;
        lo = way_sel ? l0 : l1;
        chk("resp_kind", K_RESP, e.kind);
        chk("resp_way_sel", way_sel, e.way);
        chk("resp_latency", 16'(cyc - issue_cyc), e.lat);
        chk("resp_hit_loads", lw, e.wr ? 4'b1001 : 4'b0000);
        chk("resp_other_way_loads", lo, 0);
        chk("resp_din_sel", {data_in_sel, dirty_in, pmem_read, pmem_write}, e.wr ? 4'b1100 : 4'b0000);
      end
      if (!mem_resp && !pmem_resp) chk("idle_no_loads", {l0, l1}, 0);
    end
  end

  // Abstract cache model: per-set tags/valid/dirty and LRU way.
  int ref_tag [NS][2];
  bit ref_valid [NS][2];
  bit ref_dirty [NS][2];
  bit ref_lru [NS];

  task automatic do_req(input logic [2:0] idx, input logic [3:0] tag, input bit wr,
                        input bit both, input int d);
    exp_t e;
    bit hit, got;
    int way, lat;
    hit = 1'b0; way = 0; lat = 0;
    for (int w = 0; w < 2; w++)
      if (!hit && ref_valid[idx][w] && ref_tag[idx][w] == int'(tag)) begin hit = 1'b1; way = w; end
    if (!hit) begin
      way = ref_lru[idx] ? 1 : 0;
      exp_miss++;
      lat = d + 1;
      if (ref_valid[idx][way] && ref_dirty[idx][way]) begin
        e = '{kind: K_WB, way: 1'(way), wr: 1'b0, lat: 16'd0};
        exp_q.push_back(e);
        exp_wb++;
        lat = 2 * d + 1;
      end
      e = '{kind: K_FILL, way: 1'(way), wr: 1'b0, lat: 16'd0};
      exp_q.push_back(e);
      ref_tag[idx][way] = int'(tag); ref_valid[idx][way] = 1'b1; ref_dirty[idx][way] = 1'b0;
    end
    exp_hit++;
    e = '{kind: K_RESP, way: 1'(way), wr: wr, lat: 16'(lat)};
    exp_q.push_back(e);
    ref_lru[idx] = (way == 0);
    if (wr) ref_dirty[idx][way] = 1'b1;

    @(posedge clk); #1;
    index = idx; cur_tag = tag; mem_delay = d;
    mem_write = wr; mem_read = !wr || both;
    issue_cyc = cyc;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (mem_resp) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout: no mem_resp idx=%0d tag=%0d", idx, tag);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < NS; s++) begin
      ref_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin ref_tag[s][w] = 0; ref_valid[s][w] = 1'b0; ref_dirty[s][w] = 1'b0; end
    end
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1; dp_clr = 1'b0;
    @(posedge clk);

    do_req(3'd3, 4'd0, 1'b0, 1'b0, 5);   // cold read
    do_req(3'd2, 4'd1, 1'b1, 1'b0, 2);
    do_req(3'd2, 4'd2, 1'b1, 1'b0, 2);
    do_req(3'd2, 4'd2, 1'b1, 1'b1, 1);   // write hit way 1
    do_req(3'd5, 4'd1, 1'b1, 1'b0, 3);
    do_req(3'd5, 4'd2, 1'b0, 1'b0, 2);
    do_req(3'd5, 4'd3, 1'b0, 1'b0, 3);   // dirty victim way 0
    do_req(3'd5, 4'd5, 1'b0, 1'b0, 2);   // clean victim
    do_req(3'd5, 4'd5, 1'b1, 1'b0, 1);
    do_req(3'd5, 4'd3, 1'b1, 1'b0, 1);
`ifdef CACHE_PERF_CNT_EN
    chk("hit_count_dir", hit_count, exp_hit);
    chk("miss_count_dir", miss_count, exp_miss);
    chk("wb_count_dir", wb_count, exp_wb);
`endif

    // Reset in the middle of a write-back.
    resp_en = 1'b0;
    @(posedge clk); #1;
    index = 3'd5; cur_tag = 4'd4; mem_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_wb_strobe", {pmem_write, pmem_addr_sel, way_sel}, 3'b111);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_drop", all_outs(), 0);
    cur_tag = 4'd3; mem_write = 1'b1;
    #1 chk("reset_gates_hit", all_outs(), 0);
    @(posedge clk); #1;
    chk("reset_held_outputs", all_outs(), 0);
    mem_read = 1'b0; mem_write = 1'b0; rst_n = 1'b1;
    @(negedge clk) stray = 1'b1;
    @(negedge clk);
    chk("stray_resp_seen", pmem_resp, 1);
    chk("stray_resp_no_action", all_outs(), 0);
    stray = 1'b0;
    @(negedge clk) resp_en = 1'b1;
    for (int s = 0; s < NS; s++) ref_lru[s] = 1'b0;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    do_req(3'd5, 4'd4, 1'b0, 1'b0, 2);   // victim must be way 0 after lru clear

    for (int n = 0; n < 300; n++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      do_req(3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), wr,
             wr && ($urandom_range(0, 1) == 1), $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef CACHE_PERF_CNT_EN
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
    chk("wb_count", wb_count, exp_wb);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
